// File: rtl/bakraid_prog_pkg.sv
// Shared types for the download write buffer: queued word entry, drain FSM states,
// and the lane-mask helpers used when merging mapper bytes.
package bakraid_prog_pkg;

  localparam int         PROG_AW   = 22;
  localparam logic [1:0] MASK_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PROG_AW-1:0] addr;
    logic [1:0]         ba;
    logic [15:0]        data;
    logic [1:0]         mask;
  } entry_t;

  // Odd source byte lands in the low lane (bit0), even byte in the high lane (bit1).
  function automatic logic [1:0] lane_of(input logic odd);
    return odd ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/bakraid_prog_wrbuf_if.sv
// Mapper byte-write port plus SDRAM programming port of the download write buffer.
interface bakraid_prog_wrbuf_if #(
  parameter int AW = 22
);
  logic          WR_VALID;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR;
  logic [1:0]    WR_BA;
  logic          WR_ODD;
  logic [7:0]    WR_DATA;
  logic          FLUSH;
  logic [AW-1:0] PROG_ADDR;
  logic [15:0]   PROG_DATA;
  logic [1:0]    PROG_MASK;
  logic [1:0]    PROG_BA;
  logic          PROG_WE;
  logic          PROG_RDY;
  logic          BUSY;

  modport master (
    output WR_VALID, WR_ADDR, WR_BA, WR_ODD, WR_DATA, FLUSH, PROG_RDY,
    input  WR_READY, PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA, PROG_WE, BUSY
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_BA, WR_ODD, WR_DATA, FLUSH, PROG_RDY,
    output WR_READY, PROG_ADDR, PROG_DATA, PROG_MASK, PROG_BA, PROG_WE, BUSY
  );
endinterface

// File: rtl/bakraid_prog_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and empty differ.
module bakraid_prog_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [PW:0]  o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0]  r_wptr, r_rptr;
  logic         w_do_push, w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[PW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bakraid_prog_wrbuf.sv
// Download write buffer: merges mapper bytes into 16-bit words, queues them, and drains
// them to the SDRAM programming port. Define BAKRAID_PROG_CHKSUM_EN for CHKSUM/CHKSUM_CLR.
module bakraid_prog_wrbuf
  import bakraid_prog_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 22
) (
  input  logic                CLK,
  input  logic                RESET_N,
`ifdef BAKRAID_PROG_CHKSUM_EN
  input  logic                CHKSUM_CLR,
  output logic [15:0]         CHKSUM,
`endif
  bakraid_prog_wrbuf_if.slave bus
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic          r_mr_vld;
  logic [AW-1:0] r_mr_addr;
  logic [1:0]    r_mr_ba, r_mr_lane;
  logic [15:0]   r_mr_data;
  logic          r_wr_ready, r_flush_pend;
  logic [AW-1:0] r_prog_addr;
  logic [15:0]   r_prog_data;
  logic [1:0]    r_prog_mask, r_prog_ba;
  logic          r_prog_we;
  state_t        r_state, w_state_nxt;

  entry_t        w_mr_ent, w_push_ent, w_pop_ent;
  logic          w_push, w_pop, w_full, w_empty, w_done;
  logic          w_wr_ready, w_acc, w_flush_req, w_flush_push, w_same, w_mr_load, w_mr_clr;
  logic [1:0]    w_lane;
  logic [PW:0]   w_count, w_cnt_nxt;

  assign w_wr_ready   = r_wr_ready & ~bus.FLUSH & ~r_flush_pend;
  assign w_acc        = bus.WR_VALID & w_wr_ready;
  assign w_flush_req  = bus.FLUSH | r_flush_pend;
  assign w_flush_push = w_flush_req & r_mr_vld & ~w_full;
  assign w_lane       = lane_of(bus.WR_ODD);
  assign w_same       = r_mr_vld && (r_mr_ba == bus.WR_BA) && (r_mr_addr == bus.WR_ADDR)
                        && ((r_mr_lane & w_lane) == 2'b00);
  assign w_mr_ent     = '{addr: PROG_AW'(r_mr_addr), ba: r_mr_ba, data: r_mr_data, mask: ~r_mr_lane};
  assign w_cnt_nxt    = w_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

  // Merge stage: a flush push wins; WR_READY is already low while a flush is in progress.
  always_comb begin
    w_push     = 1'b0;
    w_push_ent = w_mr_ent;
    w_mr_load  = 1'b0;
    w_mr_clr   = 1'b0;
    if (w_flush_push) begin
      w_push   = 1'b1;
      w_mr_clr = 1'b1;
    end else if (w_acc) begin
      if (!r_mr_vld) begin
        w_mr_load = 1'b1;
      end else if (w_same) begin
        w_push          = 1'b1;
        w_push_ent.data = bus.WR_ODD ? {r_mr_data[15:8], bus.WR_DATA}
                                     : {bus.WR_DATA, r_mr_data[7:0]};
        w_push_ent.mask = 2'b00;
        w_mr_clr        = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_mr_load = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mr_vld     <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_mr_load)     r_mr_vld <= 1'b1;
      else if (w_mr_clr) r_mr_vld <= 1'b0;
      r_wr_ready   <= (w_cnt_nxt < CNT_FULL);
      r_flush_pend <= w_flush_req & r_mr_vld & w_full;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mr_load) begin
      r_mr_addr <= bus.WR_ADDR;
      r_mr_ba   <= bus.WR_BA;
      r_mr_data <= {bus.WR_DATA, bus.WR_DATA};
      r_mr_lane <= w_lane;
    end
  end

  bakraid_prog_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (w_pop),
    .o_data  (w_pop_ent),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Drain stage: pop into the output registers, hold until PROG_RDY, then one gap cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_ISSUE;
                end
      ST_ISSUE: if (bus.PROG_RDY) w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done = (r_state == ST_ISSUE) & bus.PROG_RDY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_prog_we   <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= MASK_NONE;
      r_prog_ba   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_prog_we   <= 1'b1;
        r_prog_addr <= AW'(w_pop_ent.addr);
        r_prog_data <= w_pop_ent.data;
        r_prog_mask <= w_pop_ent.mask;
        r_prog_ba   <= w_pop_ent.ba;
      end else if (w_done) begin
        r_prog_we <= 1'b0;
      end
    end
  end

`ifdef BAKRAID_PROG_CHKSUM_EN
  logic [15:0] r_chksum;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        r_chksum <= '0;
    else if (CHKSUM_CLR) r_chksum <= '0;
    else if (w_done)     r_chksum <= r_chksum
                           + (r_prog_data & {{8{~r_prog_mask[1]}}, {8{~r_prog_mask[0]}}});
  end

  assign CHKSUM = r_chksum;
`endif

  assign bus.WR_READY  = w_wr_ready;
  assign bus.PROG_ADDR = r_prog_addr;
  assign bus.PROG_DATA = r_prog_data;
  assign bus.PROG_MASK = r_prog_mask;
  assign bus.PROG_BA   = r_prog_ba;
  assign bus.PROG_WE   = r_prog_we;
  assign bus.BUSY      = r_mr_vld | ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_bakraid_prog_wrbuf.sv
// Bench for bakraid_prog_wrbuf: directed and random byte streams against a queue-based model.
`timescale 1ns/1ps
module tb_bakraid_prog_wrbuf;
  localparam int DEPTH = 8;
  localparam int AW    = 22;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    ba;
    logic [15:0]   data;
    logic [1:0]    mask;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
`ifdef BAKRAID_PROG_CHKSUM_EN
  logic        chk_clr;
  logic [15:0] chksum;
`endif

  bakraid_prog_wrbuf_if #(.AW(AW)) bus ();

  bakraid_prog_wrbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
`ifdef BAKRAID_PROG_CHKSUM_EN
    .CHKSUM_CLR (chk_clr),
    .CHKSUM     (chksum),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  we_hi = 0;
  int  rdy_mode = 0;
  wr_t seen[$];

  // Reference model state
  wr_t         q[$];
  wr_t         m_mr;
  bit          m_mr_vld;
  bit          m_fpend;
  int          m_phase;    // 0 waiting for work, 1 write presented, 2 spacing cycle
  wr_t         m_out;
  bit          m_we;
  logic [15:0] m_chk;
  logic        m_we_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_mr_vld = 1'b0;
    m_fpend  = 1'b0;
    m_phase  = 0;
    m_out    = '0;
    m_out.mask = 2'b11;
    m_we     = 1'b0;
    m_chk    = '0;
  endtask

  task automatic model_step(input bit exp_ready);
    int  sz0;
    bit  do_pop, acc, freq, odd;
    wr_t popped, nb, w;
    sz0    = q.size();
    do_pop = (m_phase == 0) && (sz0 > 0);
    acc    = bus.WR_VALID && exp_ready;
    freq   = bus.FLUSH || m_fpend;
    odd    = bus.WR_ODD;
    popped = '0;
    if (do_pop) popped = q.pop_front();
    if (freq && m_mr_vld) begin
      if (sz0 < DEPTH) begin
        q.push_back(m_mr);
        m_mr_vld = 1'b0;
        m_fpend  = 1'b0;
      end else begin
        m_fpend = 1'b1;
      end
    end else begin
      m_fpend = 1'b0;
      if (acc) begin
        nb.addr = bus.WR_ADDR;
        nb.ba   = bus.WR_BA;
        nb.data = {bus.WR_DATA, bus.WR_DATA};
        nb.mask = odd ? 2'b10 : 2'b01;
        if (!m_mr_vld) begin
          m_mr = nb;
          m_mr_vld = 1'b1;
        end else if (m_mr.addr == nb.addr && m_mr.ba == nb.ba && m_mr.mask != nb.mask) begin
          w = m_mr;
          w.mask = 2'b00;
          w.data = odd ? {m_mr.data[15:8], bus.WR_DATA} : {bus.WR_DATA, m_mr.data[7:0]};
          q.push_back(w);
          m_mr_vld = 1'b0;
        end else begin
          q.push_back(m_mr);
          m_mr = nb;
        end
      end
    end
    if (do_pop) begin
      m_out   = popped;
      m_we    = 1'b1;
      m_phase = 1;
    end else if (m_phase == 1 && bus.PROG_RDY) begin
      if (!m_out.mask[1]) m_chk = m_chk + {m_out.data[15:8], 8'h00};
      if (!m_out.mask[0]) m_chk = m_chk + {8'h00, m_out.data[7:0]};
      m_we    = 1'b0;
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
`ifdef BAKRAID_PROG_CHKSUM_EN
    if (chk_clr) m_chk = '0;
`endif
  endtask

  // Compare process: mid-cycle sample of every output against the model
  initial begin : cmp
    bit  exp_ready;
    wr_t w;
    model_reset();
    m_we_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) model_reset();
      exp_ready = (q.size() < DEPTH) && !bus.FLUSH && !m_fpend;
      check("WR_READY",  32'(bus.WR_READY),  32'(exp_ready));
      check("BUSY",      32'(bus.BUSY),      32'(m_mr_vld || q.size() > 0 || m_phase != 0));
      check("PROG_WE",   32'(bus.PROG_WE),   32'(m_we));
      check("PROG_ADDR", 32'(bus.PROG_ADDR), 32'(m_out.addr));
      check("PROG_DATA", 32'(bus.PROG_DATA), 32'(m_out.data));
      check("PROG_MASK", 32'(bus.PROG_MASK), 32'(m_out.mask));
      check("PROG_BA",   32'(bus.PROG_BA),   32'(m_out.ba));
`ifdef BAKRAID_PROG_CHKSUM_EN
      check("CHKSUM",    32'(chksum),        32'(m_chk));
`endif
      if (bus.PROG_WE) we_hi++;
      if (bus.PROG_WE && !m_we_prev) begin
        w.addr = bus.PROG_ADDR;
        w.ba   = bus.PROG_BA;
        w.data = bus.PROG_DATA;
        w.mask = bus.PROG_MASK;
        seen.push_back(w);
      end
      m_we_prev = bus.PROG_WE;
      if (rst_n) model_step(exp_ready);
    end
  end

  initial begin : rdy_drv
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       bus.PROG_RDY = 1'b1;
        2:       bus.PROG_RDY = 1'($urandom_range(0, 1));
        default: bus.PROG_RDY = 1'b0;
      endcase
    end
  end

  task automatic drive_idle();
    bus.WR_VALID = 1'b0;
    bus.FLUSH    = 1'b0;
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [1:0] b,
                           input logic o, input logic [7:0] d);
    int n;
    @(negedge clk);
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR  = a;
    bus.WR_BA    = b;
    bus.WR_ODD   = o;
    bus.WR_DATA  = d;
    bus.FLUSH    = 1'b0;
    #1;
    n = 0;
    while (!bus.WR_READY && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_timeout("send_byte");
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    bus.WR_VALID = 1'b0;
    bus.FLUSH    = 1'b1;
    @(negedge clk);
    bus.FLUSH    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk);
    drive_idle();
    #3;
    n = 0;
    while (bus.BUSY && n < 2000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 2000) fail_timeout("wait_idle");
  endtask

  task automatic check_wr(input string name, input int idx, input logic [AW-1:0] a,
                          input logic [1:0] b, input logic [15:0] d, input logic [1:0] m);
    if (idx < seen.size()) begin
      check({name, " addr"}, 32'(seen[idx].addr), 32'(a));
      check({name, " ba"},   32'(seen[idx].ba),   32'(b));
      check({name, " data"}, 32'(seen[idx].data), 32'(d));
      check({name, " mask"}, 32'(seen[idx].mask), 32'(m));
    end else begin
      fail_timeout({name, " missing write"});
    end
  endtask

  initial begin : main
    int seen0, we0, n;
    rst_n        = 1'b1;
    bus.WR_VALID = 1'b0;
    bus.WR_ADDR  = '0;
    bus.WR_BA    = '0;
    bus.WR_ODD   = 1'b0;
    bus.WR_DATA  = '0;
    bus.FLUSH    = 1'b0;
    bus.PROG_RDY = 1'b0;
`ifdef BAKRAID_PROG_CHKSUM_EN
    chk_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #6;
    check("reset WR_READY",  32'(bus.WR_READY),  32'd1);
    check("reset PROG_MASK", 32'(bus.PROG_MASK), 32'd3);
    check("reset PROG_WE",   32'(bus.PROG_WE),   32'd0);
    check("reset BUSY",      32'(bus.BUSY),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Byte pair merges into one full word
    rdy_mode = 1;
    idle(2);
    seen0 = seen.size();
    we0   = we_hi;
    send_byte(22'h10, 2'd0, 1'b0, 8'hAB);
    send_byte(22'h10, 2'd0, 1'b1, 8'hCD);
    wait_idle();
    check("T1 write count", 32'(seen.size() - seen0), 32'd1);
    check_wr("T1", seen0, 22'h10, 2'd0, 16'hABCD, 2'b00);
    check("T1 WE cycles", 32'(we_hi - we0), 32'd1);

    // Lone low-lane byte committed by FLUSH
    seen0 = seen.size();
    send_byte(22'h20, 2'd3, 1'b1, 8'h5A);
    flush_pulse();
    wait_idle();
    check("T2 write count", 32'(seen.size() - seen0), 32'd1);
    check_wr("T2", seen0, 22'h20, 2'd3, 16'h5A5A, 2'b10);

    // Two high-lane bytes to different words stay separate and ordered
    seen0 = seen.size();
    send_byte(22'h30, 2'd0, 1'b0, 8'h11);
    send_byte(22'h31, 2'd0, 1'b0, 8'h22);
    flush_pulse();
    wait_idle();
    check("T3 write count", 32'(seen.size() - seen0), 32'd2);
    check_wr("T3a", seen0,     22'h30, 2'd0, 16'h1111, 2'b01);
    check_wr("T3b", seen0 + 1, 22'h31, 2'd0, 16'h2222, 2'b01);

`ifdef BAKRAID_PROG_CHKSUM_EN
    @(negedge clk) chk_clr = 1'b1;
    @(negedge clk) chk_clr = 1'b0;
    send_byte(22'h60, 2'd0, 1'b0, 8'h12);
    send_byte(22'h60, 2'd0, 1'b1, 8'h34);
    send_byte(22'h61, 2'd0, 1'b0, 8'hFF);
    send_byte(22'h61, 2'd0, 1'b1, 8'hFF);
    wait_idle();
    check("CHKSUM sum", 32'(chksum), 32'h1233);
    @(negedge clk) chk_clr = 1'b1;
    @(negedge clk) chk_clr = 1'b0;
    #1;
    check("CHKSUM clr", 32'(chksum), 32'h0);
`endif

    // Back-pressure: controller stalled, stream of distinct words
    rdy_mode = 0;
    seen0 = seen.size();
    for (int i = 0; i < 10; i++) send_byte(AW'(22'h200 + i), 2'd1, 1'b0, 8'(i + 1));
    idle(3);
    #1;
    check("T4 stall WR_READY", 32'(bus.WR_READY), 32'd0);
    check("T4 stall BUSY",     32'(bus.BUSY),     32'd1);
    rdy_mode = 2;
    flush_pulse();
    wait_idle();
    check("T4 write count", 32'(seen.size() - seen0), 32'd10);
    check_wr("T4 first", seen0,     22'h200, 2'd1, 16'h0101, 2'b01);
    check_wr("T4 last",  seen0 + 9, 22'h209, 2'd1, 16'h0A0A, 2'b01);

    // Reset while a write is presented
    rdy_mode = 0;
    send_byte(22'h40, 2'd2, 1'b0, 8'h99);
    send_byte(22'h40, 2'd2, 1'b1, 8'h66);
    n = 0;
    @(negedge clk);
    drive_idle();
    #1;
    while (!bus.PROG_WE && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) fail_timeout("T5 wait PROG_WE");
    rst_n = 1'b0;
    #1;
    check("T5 reset PROG_WE", 32'(bus.PROG_WE), 32'd0);
    check("T5 reset BUSY",    32'(bus.BUSY),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    seen0 = seen.size();
    send_byte(22'h50, 2'd1, 1'b0, 8'h77);
    send_byte(22'h50, 2'd1, 1'b1, 8'h88);
    wait_idle();
    check("T5 write count", 32'(seen.size() - seen0), 32'd1);
    check_wr("T5", seen0, 22'h50, 2'd1, 16'h7788, 2'b00);

    // Random traffic over a few colliding addresses
    rdy_mode = 2;
    repeat (400) begin
      @(negedge clk);
      bus.FLUSH    = ($urandom_range(0, 11) == 0);
      bus.WR_VALID = bus.FLUSH ? 1'b0 : 1'($urandom_range(0, 1));
      bus.WR_ADDR  = AW'(22'h100 + $urandom_range(0, 3));
      bus.WR_BA    = 2'($urandom_range(0, 1));
      bus.WR_ODD   = 1'($urandom_range(0, 1));
      bus.WR_DATA  = 8'($urandom);
    end
    flush_pulse();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bakraid_prog_wrbuf.md
Name: bakraid_prog_wrbuf

Overview:
Download write buffer between the ROM-download address mapper and the SDRAM programming port. Accepts mapped byte writes (word address, bank, byte lane, data) at ioctl rate. Merges byte pairs that target the same word into single 16-bit writes and queues them in a small FIFO. Drains the FIFO to the SDRAM controller with a PROG_WE/PROG_RDY handshake, back-pressuring the mapper when the FIFO is full.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
AW, 22, SDRAM word-address width.

Ports:
CLK  in  1  system clock; the only clock.
RESET_N  in  1  asynchronous active-low reset.
WR_VALID  in  1  byte write offered.
WR_READY  out  1  byte accepted when WR_VALID && WR_READY.
WR_ADDR  in  AW  SDRAM word address.
WR_BA  in  2  SDRAM bank.
WR_ODD  in  1  source byte address bit 0; 1 = low lane, 0 = high lane.
WR_DATA  in  8  byte data.
FLUSH  in  1  single-cycle pulse at end of download; commits any partial word.
PROG_ADDR  out  AW  word address.
PROG_DATA  out  16  write data.
PROG_MASK  out  2  lane disable; bit set = lane not written.
PROG_BA  out  2  bank.
PROG_WE  out  1  write request.
PROG_RDY  in  1  controller has completed the current write.
BUSY  out  1  partial word held, FIFO non-empty, or write in flight.

Behaviour:
- Reset values: all outputs 0 except WR_READY=1. PROG_MASK resets to 2'b11.
- Merge register (MR) holds: valid, addr, ba, data[15:0], lane-present[1:0].
- Lane mapping: WR_ODD=1 writes the low byte and clears mask bit0. WR_ODD=0 writes the high byte and clears mask bit1. Each written byte is duplicated into both halves of data, as the mapper does.
- Accepted byte, MR empty: load MR. No FIFO push.
- Accepted byte, MR holds the same {ba,addr} and the other lane: complete the word and push it with mask 2'b00. MR becomes empty in the same cycle.
- Accepted byte, different {ba,addr}, or same lane again: push the MR contents with its partial mask, then load the new byte into MR. Both happen in one cycle.
- WR_READY = FIFO has at least one free slot (count < DEPTH), registered. Every accept that may push requires a free slot.
- FLUSH: if MR is valid, push it. Pushing takes priority over a simultaneous accept. WR_READY is held low in the flush cycle.
- FIFO: DEPTH entries, entry width AW+2+16+2. Read and write pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB. Simultaneous push and pop at full is allowed; the count is unchanged.
- Drain FSM, 3 states:
  - IDLE: if the FIFO is not empty, pop and register the entry onto the PROG_* outputs, set PROG_WE=1, go to ISSUE. Latency from push to PROG_WE is 2 cycles.
  - ISSUE: hold all PROG_* outputs stable. When PROG_RDY=1, drop PROG_WE and go to GAP.
  - GAP: one idle cycle so the controller sees PROG_WE low, then return to IDLE.
- PROG_RDY is ignored outside ISSUE.
- Write ordering is strictly FIFO; no two writes are coalesced across the FIFO.
- BUSY = MR.valid | ~empty | (state != IDLE).
- Reset mid-operation: clears FIFO, MR and FSM immediately. PROG_WE drops asynchronously and the in-flight write is abandoned.
- No address arithmetic: addresses and banks pass through unchanged.

Optional Feature:
BAKRAID_PROG_CHKSUM_EN.
- When defined: adds output CHKSUM[15:0] and input CHKSUM_CLR. On each PROG_RDY in ISSUE, CHKSUM += PROG_DATA, masking disabled lanes to zero, modulo 2^16. CHKSUM_CLR (or reset) zeros it. Used to verify the downloaded image.
- When undefined: neither port exists and no accumulation logic is built.

Decomposition:
- Package bakraid_prog_pkg holds the entry struct typedef (addr, ba, data, mask), the FSM state enum (ST_IDLE, ST_ISSUE, ST_GAP) and MASK_NONE = 2'b11.
- Sub-module bakraid_prog_fifo: generic synchronous FIFO with push/pop/full/empty/count. The merge logic and drain FSM stay in the top level.

Test Plan:
- Bytes (addr 0x10, WR_ODD=0, 0xAB) then (addr 0x10, WR_ODD=1, 0xCD), PROG_RDY tied 1 → single write: PROG_ADDR=0x10, PROG_DATA=0xABCD, MASK=00, PROG_WE high for exactly 1 cycle.
- Single byte (addr 0x20, ba 3, WR_ODD=1, 0x5A) then FLUSH → write: ba=3, PROG_DATA=0x5A5A, MASK=10; BUSY falls after GAP.
- Bytes to addr 0x30 lane hi, then addr 0x31 lane hi → two writes in order, both with MASK=01.
- PROG_RDY held 0 with a continuous byte stream → WR_READY deasserts after DEPTH pushes plus the MR entry. No write is lost or duplicated; the order matches a scoreboard.
- Assert RESET_N low during ISSUE → PROG_WE=0 and BUSY=0 immediately. After release, a fresh pair produces a correct write.
- With BAKRAID_PROG_CHKSUM_EN: write words 0x1234 and 0xFFFF → CHKSUM=0x1233. Pulse CHKSUM_CLR → CHKSUM=0.
